// File: rtl/bp_me_stream_to_burst_mem_cmd_pkg.sv
// Shared BedRock memory-command types and beat arithmetic for the
// stream-to-burst command converter.
package bp_me_stream_to_burst_mem_cmd_pkg;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        bp_bedrock_mem_type_e msg_type;
        logic [3:0]           subop;
        logic [39:0]          addr;
        logic [2:0]           size;
        logic [20:0]          payload;
    } bp_bedrock_mem_header_s;

    localparam int mem_header_width_lp = $bits(bp_bedrock_mem_header_s);

    typedef enum logic {e_header, e_data} state_e;

    function automatic logic has_data(bp_bedrock_mem_header_s h);
        return (h.msg_type == e_bedrock_mem_wr)
            || (h.msg_type == e_bedrock_mem_uc_wr)
            || (h.msg_type == e_bedrock_mem_amo);
    endfunction

    // Beats needed to carry a payload of (8 << size) bits, never fewer than one.
    function automatic int unsigned bedrock_beats(logic [2:0] size, int unsigned width);
        int unsigned bits;
        bits = 32'd8 << size;
        return ((bits / width) == 0) ? 32'd1 : (bits / width);
    endfunction

endpackage

// File: rtl/bp_me_stream_to_burst_mem_cmd_if.sv
// Stream-in / burst-out memory command bundle; the converter takes the slave
// view, the upstream producer and downstream consumer take the master view.
interface bp_me_stream_to_burst_mem_cmd_if #(parameter int bedrock_data_width_p = 64);
    import bp_me_stream_to_burst_mem_cmd_pkg::*;

    bp_bedrock_mem_header_s          mem_header_i;
    logic [bedrock_data_width_p-1:0] mem_data_i;
    logic                            mem_v_i;
    logic                            mem_ready_and_o;
    logic                            mem_last_i;

    bp_bedrock_mem_header_s          mem_header_o;
    logic                            mem_header_v_o;
    logic                            mem_header_ready_and_i;
    logic                            mem_has_data_o;
    logic [bedrock_data_width_p-1:0] mem_data_o;
    logic                            mem_data_v_o;
    logic                            mem_data_ready_and_i;
    logic                            mem_last_o;

    modport slave (
        input  mem_header_i, mem_data_i, mem_v_i, mem_last_i,
               mem_header_ready_and_i, mem_data_ready_and_i,
        output mem_ready_and_o, mem_header_o, mem_header_v_o, mem_has_data_o,
               mem_data_o, mem_data_v_o, mem_last_o
    );

    modport master (
        output mem_header_i, mem_data_i, mem_v_i, mem_last_i,
               mem_header_ready_and_i, mem_data_ready_and_i,
        input  mem_ready_and_o, mem_header_o, mem_header_v_o, mem_has_data_o,
               mem_data_o, mem_data_v_o, mem_last_o
    );

endinterface

// File: rtl/bp_me_stream_to_burst_mem_cmd_beat_counter.sv
// Saturating beat counter with a latched expected length; match_o says the
// beat now being accepted would complete the message exactly.
module bp_me_stream_to_burst_mem_cmd_beat_counter #(
    parameter int unsigned width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               incr_i,
    input  logic [width_p-1:0] expected_i,
    output logic               match_o
);

    localparam logic [width_p-1:0] one_lp = width_p'(1);

    logic [width_p-1:0] count_r;
    logic [width_p-1:0] expected_r;
    logic               sat;

    assign sat = (count_r == '1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r    <= '0;
            expected_r <= '0;
        end else if (clear_i) begin
            count_r    <= '0;
            expected_r <= expected_i;
        end else if (incr_i && !sat) begin
            count_r <= count_r + one_lp;
        end
    end

    // A saturated count can no longer describe the message, so it never matches.
    assign match_o = !sat && ((count_r + one_lp) == expected_r);

endmodule

// File: rtl/bp_me_stream_to_burst_mem_cmd.sv
// Converts BedRock Stream memory commands (header repeated per beat) into
// BedRock Burst form: one header handshake, then the data beats.
module bp_me_stream_to_burst_mem_cmd
    import bp_me_stream_to_burst_mem_cmd_pkg::*;
#(
    parameter int unsigned bedrock_data_width_p = 64,
    parameter int unsigned cce_block_width_p    = 512
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    bp_me_stream_to_burst_mem_cmd_if.slave         io,
    output logic                                   len_error_o
);

    localparam int unsigned cnt_width_lp = $clog2(cce_block_width_p / bedrock_data_width_p + 1);
    localparam int unsigned cnt_max_lp   = (1 << cnt_width_lp) - 1;

    state_e                  state_r, state_n;
    logic                    runon_r, runon_n;
    logic                    hdr_has_data;
    logic                    cnt_clear, cnt_incr, cnt_match;
    logic [cnt_width_lp-1:0] expected;
    int unsigned             beats;

    logic ready_and, header_v, has_data_o, data_v, last_o, len_error;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_header;
            runon_r <= 1'b0;
        end else begin
            state_r <= state_n;
            runon_r <= runon_n;
        end
    end

    assign hdr_has_data = has_data(io.mem_header_i);

    always_comb begin
        beats    = bedrock_beats(io.mem_header_i.size, bedrock_data_width_p);
        expected = (beats > cnt_max_lp) ? '1 : cnt_width_lp'(beats);
    end

    always_comb begin
        state_n    = state_r;
        runon_n    = runon_r;
        ready_and  = 1'b0;
        header_v   = 1'b0;
        has_data_o = 1'b0;
        data_v     = 1'b0;
        last_o     = 1'b0;
        len_error  = 1'b0;
        cnt_clear  = 1'b0;
        cnt_incr   = 1'b0;
        if (!reset_i) begin
            case (state_r)
                e_header: begin
                    header_v   = io.mem_v_i;
                    has_data_o = hdr_has_data;
                    if (hdr_has_data) begin
                        if (io.mem_v_i && io.mem_header_ready_and_i) begin
                            state_n   = e_data;
                            cnt_clear = 1'b1;
                            runon_n   = 1'b0;
                        end
                    end else begin
                        ready_and = io.mem_header_ready_and_i;
                        // Dataless messages longer than one beat: flag only the first extra beat.
                        if (io.mem_v_i && io.mem_header_ready_and_i) begin
                            len_error = !io.mem_last_i && !runon_r;
                            runon_n   = !io.mem_last_i;
                        end
                    end
                end
                e_data: begin
                    data_v    = io.mem_v_i;
                    last_o    = io.mem_last_i;
                    ready_and = io.mem_data_ready_and_i;
                    if (io.mem_v_i && io.mem_data_ready_and_i) begin
                        cnt_incr = 1'b1;
                        if (io.mem_last_i) begin
                            len_error = !cnt_match;
                            state_n   = e_header;
                        end
                    end
                end
                default: state_n = e_header;
            endcase
        end
    end

    bp_me_stream_to_burst_mem_cmd_beat_counter #(.width_p(cnt_width_lp)) counter (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (cnt_clear),
        .incr_i     (cnt_incr),
        .expected_i (expected),
        .match_o    (cnt_match)
    );

    assign io.mem_ready_and_o = ready_and;
    assign io.mem_header_o    = io.mem_header_i;
    assign io.mem_header_v_o  = header_v;
    assign io.mem_has_data_o  = has_data_o;
    assign io.mem_data_o      = io.mem_data_i;
    assign io.mem_data_v_o    = data_v;
    assign io.mem_last_o      = last_o;
    assign len_error_o        = len_error;

endmodule

// File: tb/tb_bp_me_stream_to_burst_mem_cmd.sv
// Directed bench for the stream-to-burst memory command converter: a vector
// table for header-state decisions plus multi-cycle message sequences.
module tb_bp_me_stream_to_burst_mem_cmd;
    import bp_me_stream_to_burst_mem_cmd_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic len_error;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_me_stream_to_burst_mem_cmd_if #(.bedrock_data_width_p(64)) bus ();

    bp_me_stream_to_burst_mem_cmd #(
        .bedrock_data_width_p (64),
        .cce_block_width_p    (512)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .io          (bus),
        .len_error_o (len_error)
    );

    typedef struct {
        bp_bedrock_mem_type_e t;
        logic [2:0] sz;
        logic v, last, hrdy;
        logic e_ready, e_hv, e_hd, e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bp_bedrock_mem_header_s mk(bp_bedrock_mem_type_e t, logic [2:0] sz);
        bp_bedrock_mem_header_s h;
        h          = '0;
        h.msg_type = t;
        h.size     = sz;
        h.addr     = 40'h80_0000_1040;
        h.payload  = 21'h1a5;
        return h;
    endfunction

    function automatic logic [63:0] dbeat(int b);
        return 64'hD0D0_0000_0000_0000 | 64'(b);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_v_i = 1'b0;
        next_cycle();
        reset = 1'b0;
    endtask

    // Full write message: header, then nbeats data beats; toggle alternates data ready.
    task automatic write_msg(input string tag, input logic [2:0] sz, input int nbeats,
                             input logic exp_err, input logic toggle);
        int b;
        int cyc;
        logic rdy;
        bus.mem_header_i           = mk(e_bedrock_mem_wr, sz);
        bus.mem_v_i                = 1'b1;
        bus.mem_data_i             = dbeat(0);
        bus.mem_last_i             = (nbeats == 1);
        bus.mem_header_ready_and_i = 1'b1;
        bus.mem_data_ready_and_i   = 1'b0;
        #1;
        chk1({tag, " hdr_v"}, bus.mem_header_v_o, 1'b1);
        chk1({tag, " hdr_dv"}, bus.mem_data_v_o, 1'b0);
        chk1({tag, " hdr_ready"}, bus.mem_ready_and_o, 1'b0);
        chk1({tag, " hdr_has_data"}, bus.mem_has_data_o, 1'b1);
        next_cycle();
        b   = 0;
        cyc = 0;
        while (b < nbeats && cyc < 64) begin
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            bus.mem_data_ready_and_i = rdy;
            bus.mem_data_i           = dbeat(b);
            bus.mem_last_i           = (b == nbeats - 1);
            #1;
            chk1({tag, " dv"}, bus.mem_data_v_o, 1'b1);
            chk1({tag, " hv_in_data"}, bus.mem_header_v_o, 1'b0);
            chkw({tag, " data"}, 128'(bus.mem_data_o), 128'(dbeat(b)));
            chk1({tag, " ready"}, bus.mem_ready_and_o, rdy);
            chk1({tag, " last"}, bus.mem_last_o, (b == nbeats - 1));
            chk1({tag, " len_err"}, len_error, exp_err && rdy && (b == nbeats - 1));
            next_cycle();
            if (rdy) b++;
            cyc++;
        end
        chkw({tag, " beats_done"}, 128'(b), 128'(nbeats));
        bus.mem_v_i    = 1'b0;
        bus.mem_last_i = 1'b0;
    endtask

    initial begin
        vecs[0] = '{e_bedrock_mem_rd,    3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{e_bedrock_mem_uc_rd, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{e_bedrock_mem_wr,    3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{e_bedrock_mem_uc_wr, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{e_bedrock_mem_amo,   3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{e_bedrock_mem_pre,   3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{e_bedrock_mem_rd,    3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{e_bedrock_mem_wr,    3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        reset                      = 1'b1;
        bus.mem_header_i           = mk(e_bedrock_mem_rd, 3'd3);
        bus.mem_data_i             = '0;
        bus.mem_v_i                = 1'b1;
        bus.mem_last_i             = 1'b1;
        bus.mem_header_ready_and_i = 1'b1;
        bus.mem_data_ready_and_i   = 1'b1;
        next_cycle();
        next_cycle();
        chk1("rst ready", bus.mem_ready_and_o, 1'b0);
        chk1("rst hdr_v", bus.mem_header_v_o, 1'b0);
        chk1("rst data_v", bus.mem_data_v_o, 1'b0);
        chk1("rst last", bus.mem_last_o, 1'b0);
        chk1("rst len_err", len_error, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_reset();
            bus.mem_header_i           = mk(vecs[i].t, vecs[i].sz);
            bus.mem_v_i                = vecs[i].v;
            bus.mem_last_i             = vecs[i].last;
            bus.mem_header_ready_and_i = vecs[i].hrdy;
            bus.mem_data_ready_and_i   = 1'b1;
            #1;
            chk1($sformatf("vec%0d ready", i), bus.mem_ready_and_o, vecs[i].e_ready);
            chk1($sformatf("vec%0d hdr_v", i), bus.mem_header_v_o, vecs[i].e_hv);
            chk1($sformatf("vec%0d has_data", i), bus.mem_has_data_o, vecs[i].e_hd);
            chk1($sformatf("vec%0d data_v", i), bus.mem_data_v_o, 1'b0);
            chk1($sformatf("vec%0d len_err", i), len_error, vecs[i].e_err);
            chkw($sformatf("vec%0d header", i), 128'(bus.mem_header_o), 128'(mk(vecs[i].t, vecs[i].sz)));
            next_cycle();
            bus.mem_v_i = 1'b0;
        end

        do_reset();
        write_msg("wr8", 3'd6, 8, 1'b0, 1'b0);
        write_msg("wr8_stall", 3'd6, 8, 1'b0, 1'b1);
        write_msg("wr_short", 3'd6, 4, 1'b1, 1'b0);
        // Next message must be accepted with no bubble.
        bus.mem_header_i           = mk(e_bedrock_mem_uc_rd, 3'd3);
        bus.mem_v_i                = 1'b1;
        bus.mem_last_i             = 1'b1;
        bus.mem_header_ready_and_i = 1'b1;
        #1;
        chk1("b2b hdr_v", bus.mem_header_v_o, 1'b1);
        chk1("b2b ready", bus.mem_ready_and_o, 1'b1);
        chk1("b2b has_data", bus.mem_has_data_o, 1'b0);
        chk1("b2b len_err", len_error, 1'b0);
        next_cycle();
        bus.mem_v_i = 1'b0;

        // Read stalled by header ready, then a write right behind it.
        do_reset();
        bus.mem_header_i           = mk(e_bedrock_mem_uc_rd, 3'd3);
        bus.mem_v_i                = 1'b1;
        bus.mem_last_i             = 1'b1;
        bus.mem_header_ready_and_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1($sformatf("rdstall%0d hdr_v", c), bus.mem_header_v_o, 1'b1);
            chk1($sformatf("rdstall%0d ready", c), bus.mem_ready_and_o, 1'b0);
            next_cycle();
        end
        bus.mem_header_ready_and_i = 1'b1;
        #1;
        chk1("rd go ready", bus.mem_ready_and_o, 1'b1);
        next_cycle();
        bus.mem_header_i = mk(e_bedrock_mem_wr, 3'd6);
        bus.mem_last_i   = 1'b0;
        #1;
        chk1("wr_after_rd hdr_v", bus.mem_header_v_o, 1'b1);
        chk1("wr_after_rd data_v", bus.mem_data_v_o, 1'b0);
        chk1("wr_after_rd has_data", bus.mem_has_data_o, 1'b1);

        // Dataless message that runs three beats: error flagged once.
        do_reset();
        bus.mem_header_i           = mk(e_bedrock_mem_rd, 3'd3);
        bus.mem_v_i                = 1'b1;
        bus.mem_header_ready_and_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.mem_last_i = (b == 2);
            #1;
            chk1($sformatf("runon%0d hdr_v", b), bus.mem_header_v_o, 1'b1);
            chk1($sformatf("runon%0d ready", b), bus.mem_ready_and_o, 1'b1);
            chk1($sformatf("runon%0d len_err", b), len_error, (b == 0));
            next_cycle();
        end
        bus.mem_v_i = 1'b0;

        // Reset arriving on the third beat of an 8-beat write.
        do_reset();
        bus.mem_header_i           = mk(e_bedrock_mem_wr, 3'd6);
        bus.mem_v_i                = 1'b1;
        bus.mem_last_i             = 1'b0;
        bus.mem_header_ready_and_i = 1'b1;
        bus.mem_data_ready_and_i   = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        chk1("midrst ready", bus.mem_ready_and_o, 1'b0);
        chk1("midrst hdr_v", bus.mem_header_v_o, 1'b0);
        chk1("midrst data_v", bus.mem_data_v_o, 1'b0);
        chk1("midrst len_err", len_error, 1'b0);
        next_cycle();
        reset       = 1'b0;
        bus.mem_v_i = 1'b0;
        #1;
        chk1("postrst hdr_v", bus.mem_header_v_o, 1'b0);
        chk1("postrst data_v", bus.mem_data_v_o, 1'b0);
        next_cycle();
        write_msg("postrst_wr1", 3'd3, 1, 1'b0, 1'b0);

        write_msg("wr_long", 3'd3, 2, 1'b1, 1'b0);
        write_msg("wr_sat", 3'd7, 16, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
